// File: rtl/ht_cmd_initiator_pkg.sv
// Shared hash table types: opcodes, result codes, command/result/request
// structs and the result-code success helper.
package ht_cmd_initiator_pkg;

    localparam int unsigned KEY_WIDTH   = 32;
    localparam int unsigned VALUE_WIDTH = 31;

    typedef enum logic [1:0] {
        HT_SEARCH = 2'd0,
        HT_INSERT = 2'd1,
        HT_DELETE = 2'd2
    } ht_opcode_t;

    // Opcode encoding that is accepted from the host but never forwarded.
    localparam logic [1:0] HT_OP_ILLEGAL = 2'd3;

    typedef enum logic [31:0] {
        SEARCH_FOUND                     = 32'd0,
        SEARCH_NOT_FOUND                 = 32'd1,
        INSERT_SUCCESS                   = 32'd2,
        INSERT_SUCCESS_SAME_KEY          = 32'd3,
        INSERT_NOT_SUCCESS_TABLE_IS_FULL = 32'd4,
        DELETE_SUCCESS                   = 32'd5,
        DELETE_NOT_SUCCESS_NO_ENTRY      = 32'd6
    } ht_rescode_t;

    typedef struct packed {
        ht_opcode_t             opcode;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } ht_command_t;

    typedef struct packed {
        ht_command_t            cmd;
        ht_rescode_t            rescode;
        logic [VALUE_WIDTH-1:0] found_value;
    } ht_result_t;

    typedef struct packed {
        logic [1:0]             opcode;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } ht_req_t;

    // Result codes that the host sees as a successful operation.
    function automatic logic ht_rescode_ok(input ht_rescode_t rc);
        case (rc)
            SEARCH_FOUND, INSERT_SUCCESS,
            INSERT_SUCCESS_SAME_KEY, DELETE_SUCCESS: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ht_cmd_initiator_key_fifo.sv
// Key FIFO for in-flight commands: wrap-around pointers with an extra MSB,
// registered head that is valid the cycle after a push into an empty FIFO.
module ht_key_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             empty_o,
    output logic             full_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = head_q;

    // Pointer/storage update; head tracks the entry at the next read pointer,
    // bypassing push data when the FIFO is (or becomes) empty this cycle.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
        end
        if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data_i;
        end else begin
            head_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ht_cmd_initiator.sv
// Hash table client initiator: issues host requests as commands under a
// credit limit, checks in-order results against a key FIFO and returns a
// simplified response with hit/fail statistics.
module ht_cmd_initiator
    import ht_cmd_initiator_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned STAT_WIDTH      = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    input  logic [1:0]                         req_opcode_i,
    input  logic [KEY_WIDTH-1:0]               req_key_i,
    input  logic [VALUE_WIDTH-1:0]             req_value_i,
    output ht_command_t                        ht_cmd_o,
    output logic                               ht_cmd_valid_o,
    input  logic                               ht_cmd_ready_i,
    input  ht_result_t                         ht_res_i,
    input  logic                               ht_res_valid_i,
    output logic                               ht_res_ready_o,
    output logic                               rsp_valid_o,
    input  logic                               rsp_ready_i,
    output logic                               rsp_ok_o,
    output ht_rescode_t                        rsp_rescode_o,
    output logic [KEY_WIDTH-1:0]               rsp_key_o,
    output logic [VALUE_WIDTH-1:0]             rsp_value_o,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic [STAT_WIDTH-1:0]              stat_hit_cnt_o,
    output logic [STAT_WIDTH-1:0]              stat_fail_cnt_o,
    output logic                               order_err_o,
    output logic                               illegal_op_o
);

    localparam int unsigned     CW         = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0]   CREDIT_MAX = CW'(MAX_OUTSTANDING);

    ht_command_t            cmd_q, cmd_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_ok_q, rsp_ok_d;
    ht_rescode_t            rsp_rescode_q, rsp_rescode_d;
    logic [KEY_WIDTH-1:0]   rsp_key_q, rsp_key_d;
    logic [VALUE_WIDTH-1:0] rsp_value_q, rsp_value_d;
    logic [CW-1:0]          outstanding_q, outstanding_d;
    logic [STAT_WIDTH-1:0]  stat_hit_q, stat_hit_d;
    logic [STAT_WIDTH-1:0]  stat_fail_q, stat_fail_d;
    logic                   order_err_q, order_err_d;
    logic                   illegal_op_q, illegal_op_d;

    logic                   fifo_empty, fifo_full;
    logic [KEY_WIDTH-1:0]   fifo_head;
    logic                   req_fire, req_accept, res_fire, res_load, rsp_fire, res_ok;
    logic                   unused_res;

    // Opcode/value echoed in the result are not needed for the host response.
    assign unused_res = ^{ht_res_i.cmd.opcode, ht_res_i.cmd.value};

    assign req_ready_o    = (!cmd_valid_q || ht_cmd_ready_i) &&
                            (outstanding_q < CREDIT_MAX) && !fifo_full;
    assign ht_res_ready_o = !rsp_valid_q || rsp_ready_i;

    assign ht_cmd_o        = cmd_q;
    assign ht_cmd_valid_o  = cmd_valid_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_ok_o        = rsp_ok_q;
    assign rsp_rescode_o   = rsp_rescode_q;
    assign rsp_key_o       = rsp_key_q;
    assign rsp_value_o     = rsp_value_q;
    assign outstanding_o   = outstanding_q;
    assign stat_hit_cnt_o  = stat_hit_q;
    assign stat_fail_cnt_o = stat_fail_q;
    assign order_err_o     = order_err_q;
    assign illegal_op_o    = illegal_op_q;

    ht_key_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (KEY_WIDTH)
    ) u_key_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (req_accept),
        .push_data_i (req_key_i),
        .pop_i       (res_load),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .head_o      (fifo_head)
    );

    // Handshakes, command/response register loads, credits, stats and flags.
    always_comb begin
        req_fire   = req_valid_i && req_ready_o;
        req_accept = req_fire && (req_opcode_i != HT_OP_ILLEGAL);
        res_fire   = ht_res_valid_i && ht_res_ready_o;
        res_load   = res_fire && !fifo_empty;
        rsp_fire   = rsp_valid_q && rsp_ready_i;
        res_ok     = ht_rescode_ok(ht_res_i.rescode);

        cmd_d         = cmd_q;
        cmd_valid_d   = cmd_valid_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_ok_d      = rsp_ok_q;
        rsp_rescode_d = rsp_rescode_q;
        rsp_key_d     = rsp_key_q;
        rsp_value_d   = rsp_value_q;
        outstanding_d = outstanding_q;
        stat_hit_d    = stat_hit_q;
        stat_fail_d   = stat_fail_q;
        order_err_d   = order_err_q;
        illegal_op_d  = illegal_op_q;

        if (req_accept) begin
            cmd_d.opcode = ht_opcode_t'(req_opcode_i);
            cmd_d.key    = req_key_i;
            cmd_d.value  = req_value_i;
            cmd_valid_d  = 1'b1;
        end else if (ht_cmd_ready_i) begin
            cmd_valid_d  = 1'b0;
        end

        if (req_fire && (req_opcode_i == HT_OP_ILLEGAL)) begin
            illegal_op_d = 1'b1;
        end

        if (res_load) begin
            rsp_valid_d   = 1'b1;
            rsp_ok_d      = res_ok;
            rsp_rescode_d = ht_res_i.rescode;
            rsp_key_d     = ht_res_i.cmd.key;
            rsp_value_d   = (ht_res_i.rescode == SEARCH_FOUND) ? ht_res_i.found_value : '0;
            if (ht_res_i.cmd.key != fifo_head) begin
                order_err_d = 1'b1;
            end
            if ((ht_res_i.rescode == SEARCH_FOUND) && (stat_hit_q != '1)) begin
                stat_hit_d = stat_hit_q + STAT_WIDTH'(1);
            end
            if (!res_ok && (stat_fail_q != '1)) begin
                stat_fail_d = stat_fail_q + STAT_WIDTH'(1);
            end
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end

        if (res_fire && fifo_empty) begin
            order_err_d = 1'b1;
        end

        if (req_accept && !rsp_fire) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!req_accept && rsp_fire && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - CW'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cmd_q         <= '0;
            cmd_valid_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_ok_q      <= 1'b0;
            rsp_rescode_q <= ht_rescode_t'(32'd0);
            rsp_key_q     <= '0;
            rsp_value_q   <= '0;
            outstanding_q <= '0;
            stat_hit_q    <= '0;
            stat_fail_q   <= '0;
            order_err_q   <= 1'b0;
            illegal_op_q  <= 1'b0;
        end else begin
            cmd_q         <= cmd_d;
            cmd_valid_q   <= cmd_valid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_ok_q      <= rsp_ok_d;
            rsp_rescode_q <= rsp_rescode_d;
            rsp_key_q     <= rsp_key_d;
            rsp_value_q   <= rsp_value_d;
            outstanding_q <= outstanding_d;
            stat_hit_q    <= stat_hit_d;
            stat_fail_q   <= stat_fail_d;
            order_err_q   <= order_err_d;
            illegal_op_q  <= illegal_op_d;
        end
    end

endmodule

// File: tb/tb_ht_cmd_initiator.sv
// Directed self-checking bench for ht_cmd_initiator; the bench plays the
// host and the hash table, and a scoreboard queue holds expected responses.
module tb_ht_cmd_initiator;
    import ht_cmd_initiator_pkg::*;

    localparam int unsigned MAXO = 8;
    localparam int unsigned SW   = 3;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b0;
    logic                   req_valid_i = 1'b0;
    logic                   req_ready_o;
    logic [1:0]             req_opcode_i = 2'd0;
    logic [KEY_WIDTH-1:0]   req_key_i = '0;
    logic [VALUE_WIDTH-1:0] req_value_i = '0;
    ht_command_t            ht_cmd_o;
    logic                   ht_cmd_valid_o;
    logic                   ht_cmd_ready_i = 1'b1;
    ht_result_t             ht_res_i = '0;
    logic                   ht_res_valid_i = 1'b0;
    logic                   ht_res_ready_o;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i = 1'b1;
    logic                   rsp_ok_o;
    ht_rescode_t            rsp_rescode_o;
    logic [KEY_WIDTH-1:0]   rsp_key_o;
    logic [VALUE_WIDTH-1:0] rsp_value_o;
    logic [$clog2(MAXO):0]  outstanding_o;
    logic [SW-1:0]          stat_hit_cnt_o;
    logic [SW-1:0]          stat_fail_cnt_o;
    logic                   order_err_o;
    logic                   illegal_op_o;

    always #5 clk_i = ~clk_i;

    ht_cmd_initiator #(.MAX_OUTSTANDING(MAXO), .STAT_WIDTH(SW)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_opcode_i    (req_opcode_i),
        .req_key_i       (req_key_i),
        .req_value_i     (req_value_i),
        .ht_cmd_o        (ht_cmd_o),
        .ht_cmd_valid_o  (ht_cmd_valid_o),
        .ht_cmd_ready_i  (ht_cmd_ready_i),
        .ht_res_i        (ht_res_i),
        .ht_res_valid_i  (ht_res_valid_i),
        .ht_res_ready_o  (ht_res_ready_o),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_ok_o        (rsp_ok_o),
        .rsp_rescode_o   (rsp_rescode_o),
        .rsp_key_o       (rsp_key_o),
        .rsp_value_o     (rsp_value_o),
        .outstanding_o   (outstanding_o),
        .stat_hit_cnt_o  (stat_hit_cnt_o),
        .stat_fail_cnt_o (stat_fail_cnt_o),
        .order_err_o     (order_err_o),
        .illegal_op_o    (illegal_op_o)
    );

    typedef struct {
        logic                   ok;
        logic [31:0]            rc;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ok(input ht_rescode_t rc);
        return (rc == SEARCH_FOUND) || (rc == INSERT_SUCCESS) ||
               (rc == INSERT_SUCCESS_SAME_KEY) || (rc == DELETE_SUCCESS);
    endfunction

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_req(input logic [1:0] op, input logic [31:0] key,
                            input logic [30:0] val, input string tag);
        logic acc;
        acc = 1'b0;
        req_valid_i  = 1'b1;
        req_opcode_i = op;
        req_key_i    = key;
        req_value_i  = val;
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            acc = req_ready_o;
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        chk({tag, "_req_accepted"}, acc, 1'b1);
    endtask

    task automatic send_res(input logic [31:0] key, input ht_rescode_t rc,
                            input logic [30:0] fv, input bit expect_rsp, input string tag);
        logic acc;
        exp_t e;
        acc = 1'b0;
        ht_res_valid_i        = 1'b1;
        ht_res_i.cmd.opcode   = HT_SEARCH;
        ht_res_i.cmd.key      = key;
        ht_res_i.cmd.value    = '0;
        ht_res_i.rescode      = rc;
        ht_res_i.found_value  = fv;
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            acc = ht_res_ready_o;
            @(negedge clk_i);
        end
        ht_res_valid_i = 1'b0;
        chk({tag, "_res_accepted"}, acc, 1'b1);
        if (expect_rsp) begin
            e.ok    = exp_ok(rc);
            e.rc    = rc;
            e.key   = key;
            e.value = (rc == SEARCH_FOUND) ? fv : '0;
            sb.push_back(e);
        end
    endtask

    task automatic expect_rsp(input string tag);
        logic got;
        exp_t e;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        chk({tag, "_rsp_seen"}, got, 1'b1);
        chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1'b1);
        if (got && sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_ok"},      rsp_ok_o,      e.ok);
            chk({tag, "_rescode"}, rsp_rescode_o, e.rc);
            chk({tag, "_key"},     rsp_key_o,     e.key);
            chk({tag, "_value"},   rsp_value_o,   e.value);
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i          = 1'b0;
        req_valid_i    = 1'b0;
        ht_res_valid_i = 1'b0;
        ht_cmd_ready_i = 1'b1;
        rsp_ready_i    = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ht_command_t exp_cmd;
        int          cnt;
        logic        acc;

        // Reset state
        do_reset();
        chk("rst_cmd_valid", ht_cmd_valid_o, 1'b0);
        chk("rst_rsp_valid", rsp_valid_o, 1'b0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_hit", stat_hit_cnt_o, 0);
        chk("rst_fail", stat_fail_cnt_o, 0);
        chk("rst_order_err", order_err_o, 1'b0);
        chk("rst_illegal", illegal_op_o, 1'b0);
        chk("rst_res_ready", ht_res_ready_o, 1'b1);
        chk("rst_req_ready", req_ready_o, 1'b1);
        chk("rst_cmd_data", ht_cmd_o, 0);
        chk("rst_rsp_value", rsp_value_o, 0);

        // Single search hit
        send_req(2'(HT_SEARCH), 32'h10, 31'h0, "t1");
        chk("t1_cmd_valid_lat1", ht_cmd_valid_o, 1'b1);
        chk("t1_cmd_key", ht_cmd_o.key, 32'h10);
        chk("t1_cmd_op", ht_cmd_o.opcode, HT_SEARCH);
        chk("t1_outstanding", outstanding_o, 1);
        send_res(32'h10, SEARCH_FOUND, 31'h55, 1'b1, "t1");
        expect_rsp("t1");
        chk("t1_outstanding_end", outstanding_o, 0);
        chk("t1_hit", stat_hit_cnt_o, 1);
        chk("t1_fail", stat_fail_cnt_o, 0);
        chk("t1_order_err", order_err_o, 1'b0);

        // Credit limit: 9 back-to-back inserts with no results
        for (int i = 0; i < 9; i++) begin
            req_valid_i  = 1'b1;
            req_opcode_i = 2'(HT_INSERT);
            req_key_i    = 32'h100 + 32'(i);
            req_value_i  = 31'h200 + 31'(i);
            #1;
            if (i < 8) begin
                chk($sformatf("t2_ready_%0d", i), req_ready_o, 1'b1);
                @(negedge clk_i);
            end else begin
                chk("t2_ready_9th", req_ready_o, 1'b0);
                chk("t2_outstanding_full", outstanding_o, 8);
            end
        end
        send_res(32'h100, INSERT_SUCCESS, 31'h0, 1'b1, "t2_first");
        expect_rsp("t2_first");
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            #1;
            acc = req_ready_o;
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        chk("t2_9th_accepted", acc, 1'b1);
        chk("t2_outstanding_after_9th", outstanding_o, 8);
        for (int k = 1; k <= 8; k++) begin
            send_res(32'h100 + 32'(k), INSERT_SUCCESS, 31'h0, 1'b1, $sformatf("t2_drain%0d", k));
            expect_rsp($sformatf("t2_drain%0d", k));
        end
        chk("t2_outstanding_end", outstanding_o, 0);
        chk("t2_order_err", order_err_o, 1'b0);

        // Command backpressure for 3 cycles
        ht_cmd_ready_i = 1'b0;
        send_req(2'(HT_DELETE), 32'h20, 31'h0, "t3");
        exp_cmd.opcode = HT_DELETE;
        exp_cmd.key    = 32'h20;
        exp_cmd.value  = '0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_valid_hold%0d", i), ht_cmd_valid_o, 1'b1);
            chk($sformatf("t3_cmd_hold%0d", i), ht_cmd_o, exp_cmd);
            chk($sformatf("t3_req_blocked%0d", i), req_ready_o, 1'b0);
            @(negedge clk_i);
        end
        ht_cmd_ready_i = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ht_cmd_valid_o && ht_cmd_ready_i) cnt++;
            @(negedge clk_i);
        end
        chk("t3_one_cmd_issued", cnt, 1);
        send_res(32'h20, DELETE_SUCCESS, 31'h7, 1'b1, "t3");
        expect_rsp("t3");

        // Out-of-order results
        send_req(2'(HT_SEARCH), 32'h1, 31'h0, "t4a");
        send_req(2'(HT_SEARCH), 32'h2, 31'h0, "t4b");
        send_res(32'h2, SEARCH_NOT_FOUND, 31'h0, 1'b1, "t4b");
        expect_rsp("t4b");
        chk("t4_order_err_set", order_err_o, 1'b1);
        send_res(32'h1, SEARCH_FOUND, 31'h33, 1'b1, "t4a");
        expect_rsp("t4a");
        chk("t4_order_err_sticky", order_err_o, 1'b1);
        chk("t4_hit", stat_hit_cnt_o, 2);
        chk("t4_fail", stat_fail_cnt_o, 1);
        chk("t4_outstanding", outstanding_o, 0);

        // Unsolicited result and illegal opcode
        do_reset();
        chk("t5_order_err_cleared", order_err_o, 1'b0);
        send_res(32'h77, SEARCH_FOUND, 31'h1, 1'b0, "t5");
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t5_no_rsp%0d", i), rsp_valid_o, 1'b0);
            @(negedge clk_i);
        end
        chk("t5_order_err", order_err_o, 1'b1);
        chk("t5_outstanding", outstanding_o, 0);
        chk("t5_hit", stat_hit_cnt_o, 0);
        send_req(2'd3, 32'h88, 31'h0, "t5_illegal");
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t5_no_cmd%0d", i), ht_cmd_valid_o, 1'b0);
            @(negedge clk_i);
        end
        chk("t5_illegal_flag", illegal_op_o, 1'b1);
        chk("t5_outstanding_illegal", outstanding_o, 0);

        // Reset with commands in flight, then stale result and table full
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_req(2'(HT_INSERT), 32'h30 + 32'(i), 31'h1, $sformatf("t6_%0d", i));
        end
        chk("t6_outstanding4", outstanding_o, 4);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        chk("t6_cmd_valid_dropped", ht_cmd_valid_o, 1'b0);
        chk("t6_rsp_valid_dropped", rsp_valid_o, 1'b0);
        chk("t6_outstanding_dropped", outstanding_o, 0);
        chk("t6_illegal_cleared", illegal_op_o, 1'b0);
        send_res(32'h30, DELETE_NOT_SUCCESS_NO_ENTRY, 31'h0, 1'b0, "t6_stale");
        chk("t6_stale_no_rsp", rsp_valid_o, 1'b0);
        chk("t6_stale_order_err", order_err_o, 1'b1);
        send_req(2'(HT_INSERT), 32'h50, 31'h9, "t6_full");
        send_res(32'h50, INSERT_NOT_SUCCESS_TABLE_IS_FULL, 31'h0, 1'b1, "t6_full");
        expect_rsp("t6_full");
        chk("t6_fail1", stat_fail_cnt_o, 1);

        // Fail counter saturation (3-bit counters)
        for (int i = 0; i < 7; i++) begin
            send_req(2'(HT_INSERT), 32'h60 + 32'(i), 31'h2, $sformatf("t7_%0d", i));
            send_res(32'h60 + 32'(i), INSERT_NOT_SUCCESS_TABLE_IS_FULL, 31'h0, 1'b1,
                     $sformatf("t7_%0d", i));
            expect_rsp($sformatf("t7_%0d", i));
        end
        chk("t7_fail_saturated", stat_fail_cnt_o, 7);
        chk("t7_hit", stat_hit_cnt_o, 0);
        chk("t7_outstanding", outstanding_o, 0);
        chk("end_sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ht_cmd_initiator.md
Name: ht_cmd_initiator

Overview:
- Client-side initiator for the hash table command/result interface.
- Accepts host requests (opcode, key, value) and issues them as ht_command_t with valid/ready.
- Limits in-flight commands with a credit counter and collects ht_result_t in order.
- Checks result ordering against an internal key FIFO and returns a simplified host response plus statistics.
- Sits between host or test logic and the hash table top.

Parameters:
- MAX_OUTSTANDING, 8, max requests accepted but not yet delivered as responses; power of two, >= 2.
- STAT_WIDTH, 32, width of the saturating statistics counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-low
- req_valid_i  in  1  host request valid
- req_ready_o  out  1  host request ready
- req_opcode_i  in  2  ht_opcode_t
- req_key_i  in  KEY_WIDTH  key
- req_value_i  in  VALUE_WIDTH  value (used for insert only)
- ht_cmd_o  out  $bits(ht_command_t)  command to hash table
- ht_cmd_valid_o  out  1  command valid
- ht_cmd_ready_i  in  1  hash table accepts command
- ht_res_i  in  $bits(ht_result_t)  result from hash table
- ht_res_valid_i  in  1  result valid
- ht_res_ready_o  out  1  initiator accepts result
- rsp_valid_o  out  1  host response valid
- rsp_ready_i  in  1  host accepts response
- rsp_ok_o  out  1  operation succeeded
- rsp_rescode_o  out  32  ht_rescode_t passthrough
- rsp_key_o  out  KEY_WIDTH  key from result
- rsp_value_o  out  VALUE_WIDTH  found value
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current credit usage
- stat_hit_cnt_o  out  STAT_WIDTH  SEARCH_FOUND count
- stat_fail_cnt_o  out  STAT_WIDTH  non-ok result count
- order_err_o  out  1  sticky result-order error
- illegal_op_o  out  1  sticky illegal-opcode flag

Behaviour:
- Reset (rst_i==0 at a clk_i edge): ht_cmd_valid_o=0, rsp_valid_o=0, outstanding_o=0, counters=0, sticky flags=0, FIFO empty, data registers=0.
- Reset mid-operation drops all in-flight state. Results arriving afterwards are treated as unsolicited.
- Command stage: single output register.
  - req_ready_o = (!ht_cmd_valid_o || ht_cmd_ready_i) && (outstanding_o < MAX_OUTSTANDING) && !fifo_full.
  - On req handshake: load ht_cmd_o, set ht_cmd_valid_o next cycle (latency 1), push req_key_i to FIFO, outstanding +1.
  - ht_cmd_o is held stable while valid && !ready.
  - Back-to-back issue at 1 command/cycle when ht_cmd_ready_i=1.
- Illegal opcode (2'd3): request is handshaken but not forwarded, not pushed, no credit taken; illegal_op_o set.
- Response stage: single output register.
  - ht_res_ready_o = !rsp_valid_o || rsp_ready_i (combinational, 1 right after reset).
  - On result handshake with FIFO non-empty: compare ht_res_i.cmd.key to FIFO head; mismatch sets order_err_o. Pop the FIFO and load the response register, rsp_valid_o next cycle (latency 1).
  - On result handshake with FIFO empty: result is dropped, order_err_o set, no pop, no credit change.
- rsp_ok_o=1 iff rescode is SEARCH_FOUND, INSERT_SUCCESS, INSERT_SUCCESS_SAME_KEY or DELETE_SUCCESS.
- rsp_value_o = found_value if rescode==SEARCH_FOUND, else 0.
- Credits: outstanding decrements on rsp handshake (rsp_valid_o && rsp_ready_i).
  - Simultaneous accept and deliver in one cycle: outstanding unchanged.
  - Never exceeds MAX_OUTSTANDING; never underflows.
- FIFO push and pop in the same cycle are both honoured, including when the FIFO is full (pop frees the slot first) or empty (no pop).
- Statistics update on response-register load:
  - stat_hit_cnt_o +1 on SEARCH_FOUND.
  - stat_fail_cnt_o +1 when !ok.
  - Both saturate at all-ones; no wrap.
- Sticky flags clear only on reset.

Decomposition:
- Add to the shared hash_table package: ht_req_t (opcode, key, value) and the constant function ht_rescode_ok(ht_rescode_t).
- One sub-module: ht_key_fifo, a synchronous FIFO of KEY_WIDTH x MAX_OUTSTANDING.
  - Wrap-around pointers with an extra MSB for full/empty detection.
  - Outputs: empty, full, and a registered head. Head is valid the cycle after push into an empty FIFO.

Test Plan:
- Single search, hash table returns SEARCH_FOUND with found_value=31'h55, key 32'h10 -> ht_cmd_valid_o 1 cycle after req; rsp_ok_o=1, rsp_value_o=31'h55; stat_hit_cnt_o=1; outstanding_o returns to 0.
- 9 back-to-back inserts, ht_res_valid_i held 0 -> 8 accepted, req_ready_o=0 on the 9th, outstanding_o=8; one response delivered -> 9th accepted.
- ht_cmd_ready_i low 3 cycles with a command pending -> ht_cmd_o stable and valid throughout; exactly one command issued.
- Results returned with keys swapped (0x2 before 0x1) -> order_err_o=1 and stays 1; responses still delivered; stat counters correct.
- Unsolicited result with empty FIFO -> no rsp_valid_o; order_err_o=1; outstanding_o stays 0. Opcode 2'd3 request -> no ht_cmd_valid_o; illegal_op_o=1.
- rst_i=0 with 4 commands in flight -> all valids 0 and outstanding_o=0 the next cycle; DELETE_NOT_SUCCESS_NO_ENTRY after reset sets order_err_o. With a request pending, INSERT_NOT_SUCCESS_TABLE_IS_FULL gives rsp_ok_o=0 and stat_fail_cnt_o +1.
